// File: rtl/game_over_ctrl.sv
`timescale 1ns/1ps
// game_over_ctrl: Pong match sequencer. It gates play, picks the winner, and blinks and holds
// the win screen. It then pulses game_reset and waits in IDLE for the next start.
module game_over_ctrl #(
   parameter int unsigned WIN_SCORE      = 7,
   parameter int unsigned BLINK_FRAMES   = 30,
   parameter int unsigned HOLD_FRAMES    = 600,
   parameter int unsigned LOCKOUT_FRAMES = 60,
   // must match the color codes in global_symbols.vh; both nonzero so 3'b000 is blank
   parameter logic [2:0]  PLAYER_1_COLOR = 3'b100,
   parameter logic [2:0]  PLAYER_2_COLOR = 3'b001
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic       start,
   input  logic [3:0] score_p1,
   input  logic [3:0] score_p2,
   output logic       game_run,
   output logic       game_reset,
   output logic [2:0] winner,
   output logic [2:0] winner_latched
);

   localparam int unsigned HW = (HOLD_FRAMES  > 1) ? $clog2(HOLD_FRAMES)  : 1;
   localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_FRAMES - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_SHOW, S_CLEAR} state_t;

   state_t        state_q, state_d;
   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_on_q, blink_on_d;
   logic [2:0]    latched_q, latched_d;
   logic [2:0]    winner_q, winner_d;
   logic          game_run_q, game_run_d;
   logic          game_reset_q, game_reset_d;
   logic          hold_done, start_ok;

   assign hold_done = frame_tick && (hold_cnt_q == HOLD_LAST);
   assign start_ok  = start && (32'(hold_cnt_q) >= LOCKOUT_FRAMES);

   always_comb begin
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      blink_cnt_d = blink_cnt_q;
      blink_on_d  = blink_on_q;
      latched_d   = latched_q;
      case (state_q)
         S_IDLE: if (start) state_d = S_PLAY;
         S_PLAY: begin
            // fixed priority: P1 wins a same-cycle tie
            if (32'(score_p1) >= WIN_SCORE) begin
               state_d   = S_SHOW;
               latched_d = PLAYER_1_COLOR;
            end else if (32'(score_p2) >= WIN_SCORE) begin
               state_d   = S_SHOW;
               latched_d = PLAYER_2_COLOR;
            end
         end
         S_SHOW: begin
            if (hold_done || start_ok) begin
               state_d = S_CLEAR;
            end else if (frame_tick) begin
               if (hold_cnt_q != HOLD_LAST) hold_cnt_d = hold_cnt_q + 1'b1;
               if (blink_cnt_q == BLINK_LAST) begin
                  blink_cnt_d = '0;
                  blink_on_d  = ~blink_on_q;
               end else begin
                  blink_cnt_d = blink_cnt_q + 1'b1;
               end
            end
         end
         S_CLEAR: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // fresh counters with the text visible on entry; everything idle outside SHOW
      if (state_d == S_SHOW && state_q != S_SHOW) begin
         hold_cnt_d  = '0;
         blink_cnt_d = '0;
         blink_on_d  = 1'b1;
      end
      if (state_d != S_SHOW) begin
         hold_cnt_d  = '0;
         blink_cnt_d = '0;
         blink_on_d  = 1'b0;
         latched_d   = '0;
      end

      game_run_d   = (state_d == S_PLAY);
      game_reset_d = (state_d == S_CLEAR);
      winner_d     = (state_d == S_SHOW && blink_on_d) ? latched_d : 3'b000;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         hold_cnt_q   <= '0;
         blink_cnt_q  <= '0;
         blink_on_q   <= 1'b0;
         latched_q    <= '0;
         winner_q     <= '0;
         game_run_q   <= 1'b0;
         game_reset_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_cnt_q   <= hold_cnt_d;
         blink_cnt_q  <= blink_cnt_d;
         blink_on_q   <= blink_on_d;
         latched_q    <= latched_d;
         winner_q     <= winner_d;
         game_run_q   <= game_run_d;
         game_reset_q <= game_reset_d;
      end
   end

   assign game_run       = game_run_q;
   assign game_reset     = game_reset_q;
   assign winner         = winner_q;
   assign winner_latched = latched_q;

endmodule

// File: tb/tb_game_over_ctrl.sv
`timescale 1ns/1ps
// Bench for game_over_ctrl: directed test-plan scenarios plus random play, all
// compared against a frame-count model of the match sequence.
module tb_game_over_ctrl;
   localparam int WIN = 7, BLINK = 2, HOLD = 8, LOCK = 4;
   localparam logic [2:0] C1 = 3'b100, C2 = 3'b001;

   logic       clk = 1'b0, rst_n = 1'b0, frame_tick = 1'b0, start = 1'b0;
   logic [3:0] score_p1 = '0, score_p2 = '0;
   logic       game_run, game_reset;
   logic [2:0] winner, winner_latched;

   int checks = 0, failures = 0;

   typedef enum {M_IDLE, M_PLAY, M_SHOW, M_CLEAR} mph_t;
   mph_t       m_ph = M_IDLE;
   int         m_ticks = 0;
   logic [2:0] m_color = '0;
   bit         m_entry = 1'b0;

   game_over_ctrl #(
      .WIN_SCORE(WIN), .BLINK_FRAMES(BLINK), .HOLD_FRAMES(HOLD), .LOCKOUT_FRAMES(LOCK),
      .PLAYER_1_COLOR(C1), .PLAYER_2_COLOR(C2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start(start),
      .score_p1(score_p1), .score_p2(score_p2),
      .game_run(game_run), .game_reset(game_reset),
      .winner(winner), .winner_latched(winner_latched)
   );

   always #5 clk = ~clk;

   task chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task model_reset();
      m_ph = M_IDLE; m_ticks = 0; m_color = '0; m_entry = 1'b0;
   endtask

   // One clock edge of the match rules, in frame ticks seen since the win.
   task model_step();
      case (m_ph)
         M_IDLE: if (start) m_ph = M_PLAY;
         M_PLAY: begin
            if (int'(score_p1) >= WIN) begin
               m_ph = M_SHOW; m_color = C1; m_ticks = 0; m_entry = 1'b1;
            end else if (int'(score_p2) >= WIN) begin
               m_ph = M_SHOW; m_color = C2; m_ticks = 0; m_entry = 1'b1;
            end
         end
         M_SHOW: begin
            m_entry = 1'b0;
            if ((frame_tick && m_ticks + 1 == HOLD) || (start && m_ticks >= LOCK)) m_ph = M_CLEAR;
            else if (frame_tick) m_ticks++;
         end
         M_CLEAR: m_ph = M_IDLE;
         default: m_ph = M_IDLE;
      endcase
   endtask

   task check_outs(input string p);
      logic [2:0] ew, el;
      el = (m_ph == M_SHOW) ? m_color : 3'b000;
      ew = (m_ph == M_SHOW && ((m_ticks / BLINK) % 2) == 0) ? m_color : 3'b000;
      chk({p, ".run"},     8'(game_run),       8'(m_ph == M_PLAY));
      chk({p, ".reset"},   8'(game_reset),     8'(m_ph == M_CLEAR));
      chk({p, ".winner"},  8'(winner),         8'(ew));
      chk({p, ".latched"}, 8'(winner_latched), 8'(el));
   endtask

   task cyc(input string p);
      @(posedge clk);
      model_step();
      #1;
      check_outs(p);
   endtask

   logic [2:0] tbl [8];
   int rst_seen;

   initial begin
      tbl = '{C2, C2, 3'b000, 3'b000, C2, C2, 3'b000, 3'b000};

      // reset state
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outs("rst");
      rst_n = 1'b1;
      cyc("idle"); cyc("idle");

      // start pulse -> PLAY one cycle later
      start = 1'b1; cyc("start");
      chk("start.run", 8'(game_run), 8'd1);
      start = 1'b0;
      score_p1 = 4'd3; score_p2 = 4'd6;
      cyc("play"); cyc("play");

      // P2 reaches 7 with a coincident frame tick that must not count
      score_p2 = 4'd7; frame_tick = 1'b1;
      cyc("p2win");
      frame_tick = 1'b0;
      chk("p2win.winner", 8'(winner), 8'(C2));
      chk("p2win.latched", 8'(winner_latched), 8'(C2));
      chk("p2win.run", 8'(game_run), 8'd0);

      // blink pattern sampled in each tick cycle, then one game_reset
      for (int i = 0; i < 8; i++) begin
         cyc("gap");
         frame_tick = 1'b1;
         chk($sformatf("blink%0d", i), 8'(winner), 8'(tbl[i]));
         cyc("tick");
         frame_tick = 1'b0;
      end
      chk("hold.reset", 8'(game_reset), 8'd1);
      rst_seen = 0;
      for (int i = 0; i < 3; i++) begin
         cyc("after");
         if (game_reset) rst_seen++;
      end
      chk("hold.once", 8'(rst_seen), 8'd0);
      chk("hold.idle_winner", 8'(winner), 8'd0);

      // tie -> P1
      score_p1 = 4'd0; score_p2 = 4'd0;
      start = 1'b1; cyc("start2"); start = 1'b0;
      score_p1 = 4'd7; score_p2 = 4'd7;
      cyc("tie");
      chk("tie.winner", 8'(winner), 8'(C1));

      // lockout: start after 2 ticks ignored, after 4 ticks accepted
      for (int i = 0; i < 2; i++) begin
         cyc("lk"); frame_tick = 1'b1; cyc("lk"); frame_tick = 1'b0;
      end
      start = 1'b1; cyc("lk.early"); start = 1'b0;
      chk("lk.early_reset", 8'(game_reset), 8'd0);
      for (int i = 0; i < 2; i++) begin
         cyc("lk"); frame_tick = 1'b1; cyc("lk"); frame_tick = 1'b0;
      end
      start = 1'b1; cyc("lk.late"); start = 1'b0;
      chk("lk.late_reset", 8'(game_reset), 8'd1);
      cyc("lk.idle");

      // async reset mid-SHOW
      score_p1 = 4'd0; score_p2 = 4'd0;
      start = 1'b1; cyc("start3"); start = 1'b0;
      score_p1 = 4'd9;
      cyc("p1win");
      chk("pre_rst.winner", 8'(winner), 8'(C1));
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      chk("arst.winner", 8'(winner), 8'd0);
      chk("arst.latched", 8'(winner_latched), 8'd0);
      chk("arst.reset", 8'(game_reset), 8'd0);
      chk("arst.run", 8'(game_run), 8'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      score_p1 = 4'd0;
      cyc("post_rst"); cyc("post_rst"); cyc("post_rst");

      // random play
      for (int n = 0; n < 4000; n++) begin
         start = ($urandom_range(0, 7) == 0);
         case (m_ph)
            M_PLAY: begin
               if ($urandom_range(0, 3) == 0) begin
                  if ($urandom_range(0, 1) == 0) score_p1 = (score_p1 == 4'd15) ? score_p1 : score_p1 + 4'd1;
                  else                           score_p2 = (score_p2 == 4'd15) ? score_p2 : score_p2 + 4'd1;
               end
               frame_tick = ($urandom_range(0, 3) == 0);
            end
            M_SHOW: begin
               score_p1 = 4'($urandom_range(0, 15));
               score_p2 = 4'($urandom_range(0, 15));
               frame_tick = m_entry ? 1'b0 : ($urandom_range(0, 2) == 0);
            end
            default: begin
               score_p1 = 4'($urandom_range(0, 6));
               score_p2 = 4'($urandom_range(0, 6));
               frame_tick = ($urandom_range(0, 3) == 0);
            end
         endcase
         cyc("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
